// File: rtl/euler1_param_engine.sv
// Sum-of-multiples engine: accumulates every n in [0, limit) divisible by DIV_A or DIV_B
// using modulo counters, with a serial limit load port and a sliced, registered readout.
module euler1_param_engine #(
    parameter int LIMIT_W       = 10,
    parameter int SUM_W         = 18,
    parameter int SLICE_W       = 6,
    parameter int DATA_W        = 3,
    parameter int DIV_A         = 3,
    parameter int DIV_B         = 5,
    parameter int DEFAULT_LIMIT = 1000,
    parameter bit AUTO_START    = 1'b1,
    parameter int SEL_W         = (((SUM_W + SLICE_W - 1) / SLICE_W) > 1) ?
                                  $clog2((SUM_W + SLICE_W - 1) / SLICE_W) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic [DATA_W-1:0]  data_in,
    input  logic               start,
    input  logic [SEL_W-1:0]   mux_sel,
    output logic [SLICE_W-1:0] result,
    output logic               valid,
    output logic               busy,
    output logic               overflow
);

    localparam int CA_W    = $clog2(DIV_A);
    localparam int CB_W    = $clog2(DIV_B);
    localparam int SUM_XW  = SUM_W + 1;
    localparam int N_SLOTS = 1 << SEL_W;
    localparam int PAD_W   = N_SLOTS * SLICE_W;

    localparam logic [CA_W-1:0]    CA_LAST   = CA_W'(DIV_A - 1);
    localparam logic [CB_W-1:0]    CB_LAST   = CB_W'(DIV_B - 1);
    localparam logic [LIMIT_W-1:0] LIMIT_RST = LIMIT_W'(DEFAULT_LIMIT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [LIMIT_W-1:0] limit;
    logic [LIMIT_W-1:0] n;
    logic [SUM_W-1:0]   sum;
    logic [CA_W-1:0]    ca;
    logic [CB_W-1:0]    cb;
    logic [SUM_XW-1:0]  sum_ext;
    logic [PAD_W-1:0]   sum_pad;
    logic [SLICE_W-1:0] slice_next;
    logic               hit;

    // A zero residue in either counter marks n as a multiple of that divisor.
    assign hit     = (ca == '0) || (cb == '0);
    assign sum_ext = {1'b0, sum} + SUM_XW'(n);
    assign sum_pad = PAD_W'(sum);
    assign busy    = (state == RUN);

    // Slices beyond the top of the sum fall into the zero padding.
    always_comb begin
        slice_next = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (mux_sel == SEL_W'(i)) begin
                slice_next = sum_pad[i*SLICE_W +: SLICE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= AUTO_START ? RUN : IDLE;
            limit    <= LIMIT_RST;
            n        <= '0;
            sum      <= '0;
            ca       <= '0;
            cb       <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            result   <= '0;
        end else begin
            result <= slice_next;
            case (state)
                RUN: begin
                    if (n < limit) begin
                        if (hit) begin
                            sum <= sum_ext[SUM_W-1:0];
                            if (sum_ext[SUM_W]) begin
                                overflow <= 1'b1;
                            end
                        end
                        n  <= n + LIMIT_W'(1);
                        ca <= (ca == CA_LAST) ? '0 : ca + CA_W'(1);
                        cb <= (cb == CB_LAST) ? '0 : cb + CB_W'(1);
                    end else begin
                        state <= DONE;
                        valid <= 1'b1;
                    end
                end
                default: begin
                    // A limit write takes priority over a simultaneous start.
                    if (write_en) begin
                        limit <= LIMIT_W'({limit, data_in});
                    end else if (start) begin
                        n        <= '0;
                        sum      <= '0;
                        ca       <= '0;
                        cb       <= '0;
                        overflow <= 1'b0;
                        valid    <= 1'b0;
                        state    <= RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/euler1_param_engine.md
# euler1_param_engine

Parametrised sum-of-multiples engine for a TinyTapeout user slot. It accumulates every n in [0, limit) that is divisible by DIV_A or DIV_B, using modulo counters instead of division. The limit is loadable at runtime through a narrow serial write port. The wide result is read out one SLICE_W-bit slice at a time through a registered output mux. It generalises our fixed 3/5/1000 engine in divisors, limit, sum width and slice count, and adds restart, limit load and overflow flagging.

## Interface
- LIMIT_W, 10: width of limit and of the n counter.
- SUM_W, 18: accumulator width.
- SLICE_W, 6: readout slice width.
- DATA_W, 3: limit load chunk width.
- DIV_A, 3: first divisor, ≥2.
- DIV_B, 5: second divisor, ≥2.
- DEFAULT_LIMIT, 1000: limit value after reset; must be < 2^LIMIT_W.
- AUTO_START, 1: 1 = go to RUN on reset, 0 = go to IDLE on reset.
- SEL_W: derived, clog2(ceil(SUM_W/SLICE_W)), minimum 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  shift data_in into limit.
- data_in  in  DATA_W  limit load chunk.
- start  in  1  restart computation.
- mux_sel  in  SEL_W  slice index.
- result  out  SLICE_W  registered slice of sum.
- valid  out  1  computation done.
- busy  out  1  state == RUN.
- overflow  out  1  sticky, accumulator carried out.

## Operation
- States: IDLE, RUN, DONE.
- On reset:
  - limit = DEFAULT_LIMIT; n, sum, ca, cb = 0; valid = 0; overflow = 0; result = 0.
  - State = RUN if AUTO_START, else IDLE.
- RUN, when n < limit:
  - If ca == 0 or cb == 0: sum += n, modulo 2^SUM_W. Set overflow if the add carries out.
  - n += 1.
  - ca wraps at DIV_A-1; cb wraps at DIV_B-1.
- RUN, when n == limit: go to DONE and set valid = 1.
- n = 0 counts as a multiple but adds 0.
- IDLE/DONE with start = 1 and write_en = 0: clear n, sum, ca, cb, overflow and valid; go to RUN.
- IDLE/DONE with write_en = 1: limit = {limit, data_in} truncated to the low LIMIT_W bits.
- write_en beats start in the same cycle: the limit loads and start is ignored.
- RUN ignores write_en and start.
- result is registered every cycle from sum[mux_sel*SLICE_W +: SLICE_W]. Bits above SUM_W read 0; slice indices past the top read all 0.
- result tracks the live sum in every state.
- busy = (state == RUN), combinational from the state register.

## Timing
- Counting the first edge with rst low as edge 1:
  - edges 1..limit process n = 0..limit-1;
  - edge limit+1 enters DONE;
  - valid is high after edge limit+1.
- limit = 0: valid is high after edge 1 and sum = 0.
- After start is sampled, the same rule applies from the next edge.
- result latency is 1 cycle from a mux_sel or sum change.
- Reset mid-RUN: everything restarts. limit returns to DEFAULT_LIMIT; a loaded value is lost.
- valid stays high in DONE until start or rst.
- overflow is sticky until start or rst.

## Test plan
- Defaults, AUTO_START = 1, rst for one cycle:
  - valid rises after edge 1001; busy is high until then.
  - mux_sel 0/1/2 gives result 16/59/56, i.e. sum 233168; overflow = 0.
- In DONE, write 0, 0, 1, 2 (limit = 10), then pulse start:
  - valid is high after 11 edges; sum 23.
  - A start pulse during RUN is ignored.
- Load 0, 0, 0, 0 and start: valid after 1 edge, sum 0; mux_sel 3 reads 0.
- SUM_W = 16 instance with defaults: sum 36560 and overflow = 1. A following start clears overflow.
- Assert rst at RUN cycle 300: valid after edge 1001 again, sum 233168, with no residue from the partial run.
- DIV_A = 7, DIV_B = 11, limit = 100, start: sum 1153.
